// File: rtl/seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_if
//
// Purpose : Groups the datapath-facing and pin-facing signals of the
//           seven-segment scan driver into one bundle.
//
// Signals :
//   digits_in   packed 4-bit digit codes, digit i = bits [4i+3:4i]
//   digit_en    per-digit enable, 0 blanks that digit
//   load        single-cycle strobe capturing digits_in/digit_en
//   seg_out     segments {a,b,c,d,e,f,g}, active-low
//   an_out      digit anodes, active-low
//   frame_done  one-cycle pulse at the end of each full scan
//
// Modports:
//   master  the clock/counter datapath that supplies digits
//   slave   the scan driver itself
// -----------------------------------------------------------------------------
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 6
);

    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic [6:0]              seg_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_done;

    modport master (
        output digits_in,
        output digit_en,
        output load,
        input  seg_out,
        input  an_out,
        input  frame_done
    );

    modport slave (
        input  digits_in,
        input  digit_en,
        input  load,
        output seg_out,
        output an_out,
        output frame_done
    );

endinterface : seg_scan_driver_if

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Purpose : Time-multiplexed seven-segment driver. Captures NUM_DIGITS packed
//           4-bit digit codes into a shadow buffer, promotes them to the frame
//           buffer only at a frame boundary (no tearing mid-scan) and scans one
//           digit per slot onto a shared active-low segment bus with active-low
//           per-digit anode enables.
//
// Parameters:
//   NUM_DIGITS  number of digits scanned (1..16)
//   CLK_DIV     clk cycles per digit slot (>= 2)
//   HEX_MODE    0: codes 10..15 blank, 1: codes 10..15 render A,b,C,d,E,F
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    seg_scan_driver_if.slave (digits_in, digit_en, load in;
//          seg_out, an_out, frame_done out, all outputs registered)
//
// Build option:
//   SEG_SCAN_LZ_SUPPRESS_EN  when defined, zero digits above the most
//                            significant nonzero enabled digit are blanked
//                            (digit 0 is never blanked by this rule).
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_DIV    = 50000,
    parameter int HEX_MODE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    seg_scan_driver_if.slave bus
);

    // -------------------------------------------------------------------------
    // Local types and constants
    // -------------------------------------------------------------------------
    localparam int PRE_W  = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

    typedef logic [3:0]                 code_t;
    typedef logic [6:0]                 seg_t;
    typedef code_t [NUM_DIGITS-1:0]     digit_vec_t;
    typedef logic  [NUM_DIGITS-1:0]     mask_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Glyph table, bit order {a,b,c,d,e,f,g}, 0 = segment lit.
    function automatic seg_t glyph(input code_t code);
        seg_t seg;
        case (code)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            4'd10:   seg = (HEX_MODE != 0) ? 7'b0001000 : SEG_BLANK;
            4'd11:   seg = (HEX_MODE != 0) ? 7'b1100000 : SEG_BLANK;
            4'd12:   seg = (HEX_MODE != 0) ? 7'b0110001 : SEG_BLANK;
            4'd13:   seg = (HEX_MODE != 0) ? 7'b1000010 : SEG_BLANK;
            4'd14:   seg = (HEX_MODE != 0) ? 7'b0110000 : SEG_BLANK;
            4'd15:   seg = (HEX_MODE != 0) ? 7'b0111000 : SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PRE_W-1:0]  prescaler_q,      prescaler_d;
    logic [SLOT_W-1:0] slot_q,           slot_d;
    digit_vec_t        shadow_digits_q,  shadow_digits_d;
    mask_t             shadow_en_q,      shadow_en_d;
    logic              pending_q,        pending_d;
    digit_vec_t        frame_digits_q,   frame_digits_d;
    mask_t             frame_en_q,       frame_en_d;
    seg_t              seg_q,            seg_d;
    mask_t             an_q,             an_d;
    logic              frame_done_q,     frame_done_d;

    // -------------------------------------------------------------------------
    // Input view and scan-position decode
    // -------------------------------------------------------------------------
    digit_vec_t digits_in_w;
    logic       pre_wrap;     // last cycle of the current slot
    logic       frame_end;    // last cycle of the last slot
    mask_t      visible;      // digits that are actually lit this frame
    code_t      cur_code;

    assign digits_in_w = bus.digits_in;
    assign pre_wrap    = (prescaler_q == PRE_LAST);
    assign frame_end   = pre_wrap && (slot_q == SLOT_LAST);
    assign cur_code    = frame_digits_q[slot_q];

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    // Leading-zero suppression, evaluated on the frame buffer so it changes
    // only at frame boundaries together with the displayed data.
    mask_t lz_mask;

    always_comb begin
        logic seen_nonzero;
        seen_nonzero = 1'b0;
        lz_mask      = '0;
        // Walk from the most significant digit down; digit 0 is excluded so
        // an all-zero value still shows a single 0.
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (frame_en_q[i] && (frame_digits_q[i] != 4'd0)) begin
                seen_nonzero = 1'b1;
            end
            lz_mask[i] = !seen_nonzero && (frame_digits_q[i] == 4'd0);
        end
    end

    assign visible = frame_en_q & ~lz_mask;
`else
    assign visible = frame_en_q;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        prescaler_d     = prescaler_q + 1'b1;
        slot_d          = slot_q;
        shadow_digits_d = shadow_digits_q;
        shadow_en_d     = shadow_en_q;
        pending_d       = pending_q;
        frame_digits_d  = frame_digits_q;
        frame_en_d      = frame_en_q;
        seg_d           = SEG_BLANK;
        an_d            = '1;
        frame_done_d    = frame_end;

        // Slot timing.
        if (pre_wrap) begin
            prescaler_d = '0;
            slot_d      = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end

        // Frame promotion uses the shadow contents held before any load in
        // this same cycle; that load then waits for the next boundary.
        if (frame_end && pending_q) begin
            frame_digits_d = shadow_digits_q;
            frame_en_d     = shadow_en_q;
            pending_d      = 1'b0;
        end

        if (bus.load) begin
            shadow_digits_d = digits_in_w;
            shadow_en_d     = bus.digit_en;
            pending_d       = 1'b1;
        end

        // Output drive. The last cycle of every slot is left dark so the
        // anode change never overlaps segment data of the neighbouring digit.
        if (!pre_wrap && visible[slot_q]) begin
            an_d[slot_q] = 1'b0;
            seg_d        = glyph(cur_code);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every register samples the
        // pre-edge value of every other register regardless of statement order.
        if (reset) begin
            prescaler_q     <= '0;
            slot_q          <= '0;
            shadow_digits_q <= '0;
            shadow_en_q     <= '0;
            pending_q       <= 1'b0;
            frame_digits_q  <= '0;
            frame_en_q      <= '0;
            seg_q           <= SEG_BLANK;
            an_q            <= '1;
            frame_done_q    <= 1'b0;
        end else begin
            prescaler_q     <= prescaler_d;
            slot_q          <= slot_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_en_q     <= shadow_en_d;
            pending_q       <= pending_d;
            frame_digits_q  <= frame_digits_d;
            frame_en_q      <= frame_en_d;
            seg_q           <= seg_d;
            an_q            <= an_d;
            frame_done_q    <= frame_done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.seg_out    = seg_q;
    assign bus.an_out     = an_q;
    assign bus.frame_done = frame_done_q;

endmodule : seg_scan_driver
